mod_mem_arbiter: RTL and testbench
==================================

// Module: mod_mem_arbiter
// PURPOSE
//  Shares the single SRAM controller port among three requesters: instruction-miss fill,
//  data-miss fill/write-through, and VGA framebuffer fetch. Sits between the cache
//  hierarchy/VGA and the SRAM controller; one transaction outstanding at a time.
//  Priority: VGA first, with an anti-starvation cap; I/D alternate round-robin.
// PARAMETERS
//  ADDR_WIDTH     32  requester/memory address width
//  DATA_WIDTH     32  data word width
//  VGA_BURST_MAX  4   max consecutive VGA grants while a CPU request waits (>=1)
// PORTS
//  clk        in   1   system clock, all state on posedge
//  rst        in   1   asynchronous active-high reset
//  i_req      in   1   instruction fill request, held until i_rdy
//  i_addr     in   AW  instruction address, stable while i_req
//  i_rdy      out  1   one-cycle completion pulse
//  i_rdata    out  DW  read data; valid with i_rdy, held until next I completion
//  d_req      in   1   data request, held until d_rdy
//  d_rw       in   1   1=write, 0=read; stable while d_req
//  d_addr     in   AW  data address
//  d_wdata    in   DW  write data
//  d_rdy      out  1   one-cycle completion pulse
//  d_rdata    out  DW  read data (reads only); valid with d_rdy, held until next D read completion
//  v_req      in   1   VGA fetch request (read only), held until v_rdy
//  v_addr     in   AW  VGA address
//  v_rdy      out  1   one-cycle completion pulse
//  v_rdata    out  DW  read data; valid with v_rdy, held until next V completion
//  mem_req    out  1   request to SRAM controller, held until mem_ack
//  mem_rw     out  1   1=write
//  mem_addr   out  AW  latched address of granted requester
//  mem_wdata  out  DW  latched write data
//  mem_rdata  in   DW  controller read data, valid with mem_ack
//  mem_ack    in   1   one-cycle completion from controller
//  grant      out  2   owner: 00 none, 01 I, 10 D, 11 V
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; rr_ptr=D; vga_cnt=0; in-flight transaction
//   dropped; requesters re-request after reset.
//  FSM IDLE: if any req -> pick winner, latch addr/rw/wdata/grant -> BUSY; else stay.
//  FSM BUSY: mem_req=1 with latched fields; mem_ack -> capture mem_rdata into winner's
//   rdata reg, -> RESP. mem_ack in IDLE/RESP is ignored.
//  FSM RESP: winner's rdy=1 for exactly one cycle, grant cleared -> IDLE.
//  Latency: req seen in IDLE at cycle 0 -> mem_req from cycle 1; ack at cycle k ->
//   rdy at cycle k+1; next arbitration at k+2. Minimum 3 cycles per transaction.
//  Arbitration: V wins unless vga_cnt==VGA_BURST_MAX and (i_req|d_req); then CPU wins.
//   vga_cnt increments on V grant while a CPU req pending; clears on any CPU grant
//   or when no CPU req pending; saturates at VGA_BURST_MAX.
//  I vs D: both pending -> rr_ptr side wins; rr_ptr toggles to other side after each
//   I or D grant. Single CPU req wins directly; rr_ptr still updates.
//  Writes: d_rw=1 -> mem_rw=1, d_rdata unchanged, d_rdy still pulses on ack.
//  Requester dropping req mid-transaction: transaction completes, rdy pulses anyway.
//  Request raised during BUSY/RESP waits for next IDLE; no queueing beyond req level.
//  Inputs sampled only in IDLE; changes during BUSY do not affect mem_* outputs.
// TESTING
//  Single d read A=0x100, ack after 2 cycles, data 0xCAFEF00D -> mem_req 2 cyc, d_rdy 1 cyc, d_rdata=0xCAFEF00D.
//  i_req and d_req same cycle after reset -> D granted first, then I; grant 10 then 01.
//  v_req held high + d_req, VGA_BURST_MAX=4 -> grants V,V,V,V,D,V...; vga_cnt clears on D.
//  d write 0x55AA55AA to 0x200 -> mem_rw=1, mem_wdata latched, d_rdy pulse, d_rdata unchanged.
//  rst asserted mid-BUSY -> outputs 0 same cycle (async), later ack ignored, no rdy pulse.
//  mem_ack pulsed in IDLE with no req -> no state change, no rdy.

Source files
------------

// File: rtl/mod_mem_arbiter.sv
// Arbitrates one SRAM controller port among I-fill, D-fill/write and VGA fetch; one transaction in flight.
// VGA has priority up to VGA_BURST_MAX back-to-back grants while the CPU waits; I/D alternate round-robin.
module mod_mem_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int VGA_BURST_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_rdy,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_rw,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_rdy,
    output logic [DATA_WIDTH-1:0] d_rdata,
    input  logic                  v_req,
    input  logic [ADDR_WIDTH-1:0] v_addr,
    output logic                  v_rdy,
    output logic [DATA_WIDTH-1:0] v_rdata,
    output logic                  mem_req,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [1:0]            grant
);

    localparam int CW = $clog2(VGA_BURST_MAX + 1);
    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_I    = 2'b01;
    localparam logic [1:0] G_D    = 2'b10;
    localparam logic [1:0] G_V    = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state, state_nxt;
    logic [1:0]    win;
    logic          cpu_req;
    logic          vga_capped;
    logic          rr_d;        // 1: D wins an I/D tie, 0: I wins
    logic [CW-1:0] vga_cnt;

    assign cpu_req    = i_req | d_req;
    assign vga_capped = (vga_cnt == CW'(VGA_BURST_MAX)) && cpu_req;

    always_comb begin
        win = G_NONE;
        if (v_req && !vga_capped)
            win = G_V;
        else if (i_req && d_req)
            win = rr_d ? G_D : G_I;
        else if (d_req)
            win = G_D;
        else if (i_req)
            win = G_I;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win != G_NONE) state_nxt = BUSY;
            BUSY:    if (mem_ack) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant     <= G_NONE;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            v_rdata   <= '0;
            rr_d      <= 1'b1;
            vga_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // The VGA streak only counts while the CPU is actually being held off.
                    if (!cpu_req)
                        vga_cnt <= '0;
                    else if (win == G_V)
                        vga_cnt <= (vga_cnt == CW'(VGA_BURST_MAX)) ? vga_cnt : vga_cnt + 1'b1;
                    else if (win != G_NONE)
                        vga_cnt <= '0;

                    if (win == G_I) rr_d <= 1'b1;
                    if (win == G_D) rr_d <= 1'b0;

                    if (win != G_NONE) begin
                        grant     <= win;
                        mem_addr  <= (win == G_V) ? v_addr : (win == G_D) ? d_addr : i_addr;
                        mem_rw    <= (win == G_D) && d_rw;
                        mem_wdata <= (win == G_D) ? d_wdata : '0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        case (grant)
                            G_I:     i_rdata <= mem_rdata;
                            G_D:     if (!mem_rw) d_rdata <= mem_rdata;
                            G_V:     v_rdata <= mem_rdata;
                            default: ;
                        endcase
                    end
                end
                RESP:    grant <= G_NONE;
                default: ;
            endcase
        end
    end

    assign mem_req = (state == BUSY);
    assign i_rdy   = (state == RESP) && (grant == G_I);
    assign d_rdy   = (state == RESP) && (grant == G_D);
    assign v_rdy   = (state == RESP) && (grant == G_V);

endmodule

// File: tb/tb_mod_mem_arbiter.sv
// Bench for mod_mem_arbiter: requester/responder agents, transaction-level reference model, directed scenarios.
module tb_mod_mem_arbiter;

    localparam int VMAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 0, d_req = 0, v_req = 0, d_rw = 0, mem_ack = 0;
    logic [31:0] i_addr = 0, d_addr = 0, v_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic        i_rdy, d_rdy, v_rdy, mem_req, mem_rw;
    logic [31:0] i_rdata, d_rdata, v_rdata, mem_addr, mem_wdata;
    logic [1:0]  grant;

    mod_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .VGA_BURST_MAX(VMAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_rdata(i_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdy(d_rdy), .d_rdata(d_rdata),
        .v_req(v_req), .v_addr(v_addr), .v_rdy(v_rdy), .v_rdata(v_rdata),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant(grant)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          m_phase;      // 0 no transaction, 1 waiting for ack, 2 responding
    logic [1:0]  m_own, m_win;
    logic [31:0] m_addr, m_wdata, m_irdata, m_drdata, m_vrdata;
    logic        m_rw, m_rr_d;
    int          m_cnt;

    function automatic logic [1:0] pick(input logic ir, input logic dr, input logic vr,
                                        input int cnt, input logic rrd);
        if (vr && !(cnt == VMAX && (ir || dr))) return 2'd3;
        if (ir && dr) return rrd ? 2'd2 : 2'd1;
        if (dr) return 2'd2;
        if (ir) return 2'd1;
        return 2'd0;
    endfunction

    assign m_win = pick(i_req, d_req, v_req, m_cnt, m_rr_d);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_own <= 0; m_addr <= 0; m_wdata <= 0; m_rw <= 0;
            m_irdata <= 0; m_drdata <= 0; m_vrdata <= 0; m_rr_d <= 1; m_cnt <= 0;
        end else if (m_phase == 0) begin
            if (!(i_req || d_req)) m_cnt <= 0;
            else if (m_win == 2'd3) m_cnt <= (m_cnt < VMAX) ? m_cnt + 1 : VMAX;
            else if (m_win != 2'd0) m_cnt <= 0;
            if (m_win == 2'd1) m_rr_d <= 1;
            if (m_win == 2'd2) m_rr_d <= 0;
            if (m_win != 2'd0) begin
                m_own   <= m_win;
                m_phase <= 1;
                m_addr  <= (m_win == 2'd3) ? v_addr : (m_win == 2'd2) ? d_addr : i_addr;
                m_rw    <= (m_win == 2'd2) && d_rw;
                m_wdata <= (m_win == 2'd2) ? d_wdata : 32'd0;
            end
        end else if (m_phase == 1) begin
            if (mem_ack) begin
                m_phase <= 2;
                if (m_own == 2'd1) m_irdata <= mem_rdata;
                if (m_own == 2'd2 && !m_rw) m_drdata <= mem_rdata;
                if (m_own == 2'd3) m_vrdata <= mem_rdata;
            end
        end else begin
            m_phase <= 0;
        end
    end

    logic chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req",   {31'd0, mem_req}, {31'd0, m_phase == 1});
            chk("grant",     {30'd0, grant},   (m_phase != 0) ? {30'd0, m_own} : 32'd0);
            chk("i_rdy",     {31'd0, i_rdy},   {31'd0, m_phase == 2 && m_own == 2'd1});
            chk("d_rdy",     {31'd0, d_rdy},   {31'd0, m_phase == 2 && m_own == 2'd2});
            chk("v_rdy",     {31'd0, v_rdy},   {31'd0, m_phase == 2 && m_own == 2'd3});
            chk("mem_addr",  mem_addr,  m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_rw",    {31'd0, mem_rw},  {31'd0, m_rw});
            chk("i_rdata",   i_rdata, m_irdata);
            chk("d_rdata",   d_rdata, m_drdata);
            chk("v_rdata",   v_rdata, m_vrdata);
        end
    end

    // ---------------- monitors ----------------
    logic       clr_mon = 0;
    int         n_memreq, n_irdy, n_drdy, n_vrdy;
    logic       seen_rw;
    logic [31:0] seen_wdata;
    logic [1:0] prev_grant;
    logic [1:0] glog[$];

    always @(negedge clk) begin
        prev_grant <= grant;
        if (clr_mon) begin
            n_memreq <= 0; n_irdy <= 0; n_drdy <= 0; n_vrdy <= 0;
            seen_rw <= 0; seen_wdata <= 0;
            glog.delete();
        end else begin
            if (mem_req) begin
                n_memreq   <= n_memreq + 1;
                seen_rw    <= mem_rw;
                seen_wdata <= mem_wdata;
            end
            if (i_rdy) n_irdy <= n_irdy + 1;
            if (d_rdy) n_drdy <= n_drdy + 1;
            if (v_rdy) n_vrdy <= n_vrdy + 1;
            if (grant != 2'd0 && prev_grant == 2'd0) glog.push_back(grant);
        end
    end

    // ---------------- requester agents ----------------
    int          i_target = 0, d_target = 0, v_target = 0;
    int          i_issued = 0, d_issued = 0, v_issued = 0;
    int          i_done = 0, d_done = 0, v_done = 0;
    logic [31:0] i_base = 0, d_base = 0, v_base = 32'h8000;
    logic        d_rw_cfg = 0;
    logic [31:0] d_wdata_cfg = 0;
    logic        si, sd, sv;

    initial begin
        forever begin
            @(negedge clk);
            si = i_rdy; sd = d_rdy; sv = v_rdy;
            @(posedge clk); #2;
            if (rst) begin
                i_req = 0; d_req = 0; v_req = 0;
                i_issued = i_done; d_issued = d_done; v_issued = v_done;
            end else begin
                if (i_req && si) begin i_done++; i_req = 0; end
                if (!i_req && i_issued < i_target) begin
                    i_req = 1; i_addr = i_base; i_issued++;
                end
                if (d_req && sd) begin d_done++; d_req = 0; end
                if (!d_req && d_issued < d_target) begin
                    d_req = 1; d_addr = d_base; d_rw = d_rw_cfg; d_wdata = d_wdata_cfg; d_issued++;
                end
                if (v_req && sv) begin v_done++; v_req = 0; end
                if (!v_req && v_issued < v_target) begin
                    v_req = 1; v_addr = v_base + 32'(16 * v_issued); v_issued++;
                end
            end
        end
    end

    // ---------------- memory responder ----------------
    logic        auto_en = 1, ack_force = 0, force_en = 0;
    logic [31:0] force_data = 0;
    int          ack_lat = 2;
    int          wcnt = 0;

    initial begin
        forever begin
            @(posedge clk); #2;
            if (rst || mem_ack) begin
                mem_ack = 0;
                wcnt = 0;
            end else if (ack_force) begin
                mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
            end else if (auto_en && mem_req) begin
                wcnt++;
                if (wcnt >= ack_lat) begin
                    mem_ack = 1;
                    mem_rdata = force_en ? force_data : (mem_addr ^ 32'h3C3C0000);
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic clear_mon();
        clr_mon = 1;
        @(negedge clk); #1;
        clr_mon = 0;
    endtask

    task automatic wait_all(input int maxc);
        int n = 0;
        while (!(i_done == i_target && d_done == d_target && v_done == v_target) && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(i_done == i_target && d_done == d_target && v_done == v_target)) begin
            checks++; errors++;
            $display("FAIL timeout: requests still open after %0d cycles", maxc);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_grant",   {30'd0, grant},   32'd0);
        chk("rst_rdy",     {29'd0, i_rdy, d_rdy, v_rdy}, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        rst = 0;
        repeat (2) @(posedge clk);
        #1;

        // single D read, ack after two cycles
        clear_mon();
        force_en = 1; force_data = 32'hCAFEF00D; ack_lat = 2; d_base = 32'h100;
        d_target += 1;
        wait_all(50);
        chk("rd_memreq_cycles", n_memreq, 32'd2);
        chk("rd_drdy_cycles",   n_drdy,   32'd1);
        chk("rd_d_rdata",       d_rdata,  32'hCAFEF00D);
        chk("rd_mem_addr",      mem_addr, 32'h100);
        force_en = 0;

        // D write leaves d_rdata alone
        clear_mon();
        d_base = 32'h200; d_rw_cfg = 1; d_wdata_cfg = 32'h55AA55AA;
        d_target += 1;
        wait_all(50);
        chk("wr_mem_rw",    {31'd0, seen_rw}, 32'd1);
        chk("wr_mem_wdata", seen_wdata, 32'h55AA55AA);
        chk("wr_mem_addr",  mem_addr, 32'h200);
        chk("wr_drdy",      n_drdy, 32'd1);
        chk("wr_d_rdata",   d_rdata, 32'hCAFEF00D);
        d_rw_cfg = 0;

        // I and D together after reset: D first
        pulse_reset();
        clear_mon();
        i_base = 32'h1000; d_base = 32'h300;
        i_target += 1; d_target += 1;
        wait_all(60);
        chk("id_count",  glog.size(), 32'd2);
        if (glog.size() >= 2) begin
            chk("id_first",  {30'd0, glog[0]}, 32'd2);
            chk("id_second", {30'd0, glog[1]}, 32'd1);
        end
        chk("id_i_rdata", i_rdata, 32'h3C3C1000);
        chk("id_d_rdata", d_rdata, 32'h3C3C0300);

        // VGA burst cap with D waiting
        clear_mon();
        ack_lat = 1;
        v_target += 7; d_target += 1;
        wait_all(200);
        chk("vd_count", glog.size(), 32'd8);
        if (glog.size() >= 6) begin
            chk("vd_g0", {30'd0, glog[0]}, 32'd3);
            chk("vd_g1", {30'd0, glog[1]}, 32'd3);
            chk("vd_g2", {30'd0, glog[2]}, 32'd3);
            chk("vd_g3", {30'd0, glog[3]}, 32'd3);
            chk("vd_g4", {30'd0, glog[4]}, 32'd2);
            chk("vd_g5", {30'd0, glog[5]}, 32'd3);
        end
        chk("vd_vrdy", n_vrdy, 32'd7);

        // stray ack while idle
        clear_mon();
        ack_force = 1;
        @(posedge clk); #1;
        ack_force = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ack_rdy",    n_irdy + n_drdy + n_vrdy, 32'd0);
        chk("idle_ack_memreq", n_memreq, 32'd0);
        chk("idle_ack_grant",  {30'd0, grant}, 32'd0);

        // reset mid-transaction
        clear_mon();
        auto_en = 0; d_base = 32'h400;
        d_target += 1;
        begin
            int n = 0;
            while (!mem_req && n < 20) begin @(posedge clk); #1; n++; end
        end
        chk("mid_busy_reached", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #3;
        rst = 1;
        #1;
        chk("mid_rst_memreq", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_grant",  {30'd0, grant},   32'd0);
        chk("mid_rst_d_rdata", d_rdata, 32'd0);
        d_target = d_done;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        ack_force = 1;
        @(posedge clk); #1;
        ack_force = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_rst_no_rdy", n_drdy, 32'd0);
        chk("mid_rst_idle",   {30'd0, grant}, 32'd0);
        auto_en = 1;

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
